// File: rtl/fsk_pkg.sv
// fsk_pkg: shared types, constants and phase arithmetic for the FSK modulator.
`timescale 1ns/1ps

package fsk_pkg;

    // Transmitter states: IDLE has no bit in flight, SEND is emitting cur_bit.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int              PHASE_W     = 9;
    localparam int              PHASE_MOD   = 360;
    localparam int              SAMPLE_W    = 8;
    localparam logic [7:0]      MIDSCALE    = 8'd128;
    localparam logic [PHASE_W:0] PHASE_MOD_W = 10'(PHASE_MOD);

    // Advance a table phase by step entries, modulo 360. Steps never exceed
    // 179, so the widened sum stays below 720 and one subtraction suffices.
    function automatic logic [PHASE_W-1:0] phase_advance(
        input logic [PHASE_W-1:0] phase,
        input logic [PHASE_W-1:0] step
    );
        logic [PHASE_W:0] sum;
        sum = {1'b0, phase} + {1'b0, step};
        if (sum >= PHASE_MOD_W) begin
            sum = sum - PHASE_MOD_W;
        end
        return sum[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/fsk_sine_rom.sv
// fsk_sine_rom: combinational 360-entry sine lookup, sine[k] = 128 + round(127*sin(2*pi*k/360)).
// Only the quarter wave k=0..90 is stored; the other quadrants are produced by
// mirroring the index and reflecting the value about midscale (256 - q).
`timescale 1ns/1ps

module fsk_sine_rom
    import fsk_pkg::*;
(
    input  logic [PHASE_W-1:0]  phase,
    output logic [SAMPLE_W-1:0] sample
);

    // Quarter-wave table, k = 0..90.
    localparam logic [7:0] QUARTER [0:90] = '{
        8'd128, 8'd130, 8'd132, 8'd135, 8'd137, 8'd139, 8'd141, 8'd143, 8'd146, 8'd148,
        8'd150, 8'd152, 8'd154, 8'd157, 8'd159, 8'd161, 8'd163, 8'd165, 8'd167, 8'd169,
        8'd171, 8'd174, 8'd176, 8'd178, 8'd180, 8'd182, 8'd184, 8'd186, 8'd188, 8'd190,
        8'd192, 8'd193, 8'd195, 8'd197, 8'd199, 8'd201, 8'd203, 8'd204, 8'd206, 8'd208,
        8'd210, 8'd211, 8'd213, 8'd215, 8'd216, 8'd218, 8'd219, 8'd221, 8'd222, 8'd224,
        8'd225, 8'd227, 8'd228, 8'd229, 8'd231, 8'd232, 8'd233, 8'd235, 8'd236, 8'd237,
        8'd238, 8'd239, 8'd240, 8'd241, 8'd242, 8'd243, 8'd244, 8'd245, 8'd246, 8'd247,
        8'd247, 8'd248, 8'd249, 8'd249, 8'd250, 8'd251, 8'd251, 8'd252, 8'd252, 8'd253,
        8'd253, 8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
        8'd255
    };

    logic [6:0] mirror_idx;
    logic       reflect;
    logic [7:0] quarter_val;

    // Fold the phase into the first quadrant, then reflect for the negative half-cycle.
    always_comb begin
        mirror_idx = 7'd0;
        reflect    = 1'b0;
        if (phase <= 9'd90) begin
            mirror_idx = phase[6:0];
        end else if (phase <= 9'd180) begin
            mirror_idx = 7'(9'd180 - phase);
        end else if (phase <= 9'd270) begin
            mirror_idx = 7'(phase - 9'd180);
            reflect    = 1'b1;
        end else if (phase < 9'd360) begin
            mirror_idx = 7'(9'd360 - phase);
            reflect    = 1'b1;
        end else begin
            // Unreachable phase codes fall back to midscale.
            mirror_idx = 7'd0;
            reflect    = 1'b0;
        end
        quarter_val = QUARTER[mirror_idx];
        sample      = reflect ? 8'(9'd256 - {1'b0, quarter_val}) : quarter_val;
    end

endmodule

// File: rtl/fsk_modulator.sv
// fsk_modulator: binary FSK transmitter. Accepts one bit per valid/ready
// handshake and emits SAMPLES_PER_BIT continuous-phase sine samples per bit.
// Optional build macro FSK_IDLE_MARK_EN: when defined, IDLE transmits the mark
// tone continuously instead of sitting silent at midscale.
`timescale 1ns/1ps

module fsk_modulator
    import fsk_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = 1500,
    parameter int STEP_MARK       = 2,
    parameter int STEP_SPACE      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bit_valid,
    input  logic                bit_in,
    output logic                bit_ready,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid
);

    localparam int                 CNT_W        = (SAMPLES_PER_BIT > 2) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [PHASE_W-1:0] STEP_MARK_P  = PHASE_W'(STEP_MARK);
    localparam logic [PHASE_W-1:0] STEP_SPACE_P = PHASE_W'(STEP_SPACE);

    state_t                state_reg,        state_next;
    logic [CNT_W-1:0]      cnt_reg,          cnt_next;
    logic                  cur_bit_reg,      cur_bit_next;
    logic [PHASE_W-1:0]    phase_reg,        phase_next;
    logic [SAMPLE_W-1:0]   sample_reg,       sample_next;
    logic                  sample_valid_reg, sample_valid_next;

    logic [SAMPLE_W-1:0]   rom_sample;
    logic                  cnt_last;
    logic                  xfer;

    // Table lookup is combinational from the phase register; its output is
    // registered into sample so no input reaches the sample outputs directly.
    fsk_sine_rom u_rom (
        .phase  (phase_reg),
        .sample (rom_sample)
    );

    // Next-state, handshake and datapath decisions; defaults hold every register.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        cur_bit_next      = cur_bit_reg;
        phase_next        = phase_reg;
        sample_next       = sample_reg;
        sample_valid_next = sample_valid_reg;

        cnt_last  = (cnt_reg == CNT_LAST);
        // Ready depends on state only, so a new bit lands exactly as the last
        // sample of the current bit leaves and back-to-back bits are gapless.
        bit_ready = (state_reg == IDLE) || ((state_reg == SEND) && cnt_last);
        xfer      = bit_valid && bit_ready;

        case (state_reg)
            IDLE: begin
`ifdef FSK_IDLE_MARK_EN
                // Keep the carrier up with the mark tone; phase keeps running so
                // the next burst continues from wherever the tone is.
                sample_next       = rom_sample;
                sample_valid_next = 1'b1;
                phase_next        = phase_advance(phase_reg, STEP_MARK_P);
`else
                // Silence at midscale; every burst restarts at phase 0.
                sample_next       = MIDSCALE;
                sample_valid_next = 1'b0;
                phase_next        = '0;
`endif
                if (xfer) begin
                    cur_bit_next = bit_in;
                    cnt_next     = '0;
                    state_next   = SEND;
                end
            end

            SEND: begin
                sample_next       = rom_sample;
                sample_valid_next = 1'b1;
                phase_next        = phase_advance(phase_reg,
                                                  cur_bit_reg ? STEP_MARK_P : STEP_SPACE_P);
                cnt_next          = cnt_reg + CNT_W'(1);
                if (cnt_last) begin
                    // This edge still emits the final sample of the old bit.
                    cnt_next = '0;
                    if (xfer) begin
                        cur_bit_next = bit_in;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any bit in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            cur_bit_reg      <= 1'b0;
            phase_reg        <= '0;
            sample_reg       <= MIDSCALE;
            sample_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            cur_bit_reg      <= cur_bit_next;
            phase_reg        <= phase_next;
            sample_reg       <= sample_next;
            sample_valid_reg <= sample_valid_next;
        end
    end

    assign sample       = sample_reg;
    assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_fsk_modulator.sv
// tb_fsk_modulator: scoreboard bench for fsk_modulator (default build).
// Instance a uses the default parameters; instance b uses SAMPLES_PER_BIT=4,
// STEP_MARK=179 to exercise short bits, the ready pattern and phase wrap.
`timescale 1ns/1ps

module tb_fsk_modulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_bv, a_bi, a_rdy, a_sv;
    logic [7:0] a_s;
    logic       b_bv, b_bi, b_rdy, b_sv;
    logic [7:0] b_s;

    always #5 clk = ~clk;

    fsk_modulator #(.SAMPLES_PER_BIT(1500), .STEP_MARK(2), .STEP_SPACE(1)) dut_a (
        .clk(clk), .rst(rst), .bit_valid(a_bv), .bit_in(a_bi),
        .bit_ready(a_rdy), .sample(a_s), .sample_valid(a_sv)
    );

    fsk_modulator #(.SAMPLES_PER_BIT(4), .STEP_MARK(179), .STEP_SPACE(1)) dut_b (
        .clk(clk), .rst(rst), .bit_valid(b_bv), .bit_in(b_bi),
        .bit_ready(b_rdy), .sample(b_s), .sample_valid(b_sv)
    );

    // kind 0: state check, kind 1: sample queue drained, kind 2: timed out
    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] s;
        logic       v;
        logic       r;
        bit         cs;
        bit         cv;
        bit         cr;
        string      name;
    } req_t;

    req_t       reqs[$];
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         checks = 0;
    int         errors = 0;

    logic [7:0] a_spot[int];
    int         a_phase;
    int         a_pushed;

    // Hand-computed: phases 0,179,358,177,356,175,354,173 and 0,1,2,3.
    logic [7:0] wrap_exp   [0:7] = '{8'd128, 8'd130, 8'd124, 8'd135, 8'd119, 8'd139, 8'd115, 8'd143};
    logic [7:0] space4_exp [0:3] = '{8'd128, 8'd130, 8'd132, 8'd135};

    function automatic logic [7:0] sine_ref(input int k);
        real v;
        int  r;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 360.0);
        if (v >= 0.0) r = int'(v + 1.0e-6);
        else          r = int'(v - 1.0e-6);
        return 8'(128 + r);
    endfunction

    // Monitor: pops the scoreboard on every valid sample, then services checks.
    always @(negedge clk) begin : monitor
        req_t       r;
        logic [7:0] e;
        logic [7:0] act_s;
        logic       act_v;
        logic       act_r;
        int         qlen;
        if (!rst && a_sv) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_stream: got sample %0d, expected no valid sample", a_s);
            end else begin
                e = qa.pop_front();
                if (a_s !== e) begin
                    errors++;
                    $display("FAIL a_stream: got %0d, expected %0d (%0d left)", a_s, e, qa.size());
                end
            end
        end
        if (!rst && b_sv) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_stream: got sample %0d, expected no valid sample", b_s);
            end else begin
                e = qb.pop_front();
                if (b_s !== e) begin
                    errors++;
                    $display("FAIL b_stream: got %0d, expected %0d (%0d left)", b_s, e, qb.size());
                end
            end
        end
        while (reqs.size() > 0) begin
            r     = reqs.pop_front();
            act_s = (r.dut == 0) ? a_s   : b_s;
            act_v = (r.dut == 0) ? a_sv  : b_sv;
            act_r = (r.dut == 0) ? a_rdy : b_rdy;
            qlen  = (r.dut == 0) ? qa.size() : qb.size();
            checks++;
            case (r.kind)
                0: begin
                    if ((r.cs && act_s !== r.s) || (r.cv && act_v !== r.v) || (r.cr && act_r !== r.r)) begin
                        errors++;
                        $display("FAIL %s: got sample=%0d valid=%b ready=%b, expected sample=%0d valid=%b ready=%b",
                                 r.name, act_s, act_v, act_r, r.s, r.v, r.r);
                    end
                end
                1: begin
                    if (qlen != 0) begin
                        errors++;
                        $display("FAIL %s: %0d expected samples never appeared, expected 0", r.name, qlen);
                    end
                end
                default: begin
                    errors++;
                    $display("FAIL %s: handshake never completed, expected bit_ready within budget", r.name);
                end
            endcase
        end
    end

    task automatic expect_state(input int d, input string nm, input bit cs, input logic [7:0] s,
                                input bit cv, input logic v, input bit cr, input logic r);
        req_t q;
        q.dut = d; q.kind = 0; q.name = nm;
        q.cs = cs; q.s = s; q.cv = cv; q.v = v; q.cr = cr; q.r = r;
        reqs.push_back(q);
    endtask

    task automatic expect_req(input int d, input int kind, input string nm);
        req_t q;
        q.dut = d; q.kind = kind; q.name = nm;
        q.cs = 1'b0; q.s = 8'd0; q.cv = 1'b0; q.v = 1'b0; q.cr = 1'b0; q.r = 1'b0;
        reqs.push_back(q);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a bit and return just after the edge on which it was taken.
    task automatic xfer(input int d, input logic b);
        int    n;
        string nm;
        n  = 0;
        nm = (d == 0) ? "a_xfer_timeout" : "b_xfer_timeout";
        if (d == 0) begin a_bv = 1'b1; a_bi = b; end
        else        begin b_bv = 1'b1; b_bi = b; end
        while (((d == 0) ? a_rdy : b_rdy) !== 1'b1 && n < 4000) begin
            tick(1);
            n++;
        end
        if (n >= 4000) expect_req(d, 2, nm);
        else           tick(1);
    endtask

    task automatic push_model_a(input logic b);
        for (int i = 0; i < 1500; i++) begin
            if (a_spot.exists(a_pushed)) qa.push_back(a_spot[a_pushed]);
            else                         qa.push_back(sine_ref(a_phase));
            a_phase = (a_phase + (b ? 2 : 1)) % 360;
            a_pushed++;
        end
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation still running at 5 ms, expected to finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        a_bv = 1'b0; a_bi = 1'b0;
        b_bv = 1'b0; b_bi = 1'b0;
        tick(2);
        rst = 1'b0;
        expect_state(0, "a_reset_state", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        expect_state(1, "b_reset_state", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        tick(2);

        // Single mark bit from idle: phase 0,2,4,...; #45 peak, #135 trough.
        a_spot.delete(); a_spot[45] = 8'd255; a_spot[135] = 8'd1;
        a_phase = 0; a_pushed = 0;
        xfer(0, 1'b1);
        a_bv = 1'b0;
        push_model_a(1'b1);
        expect_state(0, "a_ready_busy", 0, 8'd0, 0, 1'b0, 1, 1'b0);
        tick(1500);
        expect_req(0, 1, "a_single_drain");
        tick(1);
        expect_state(0, "a_single_idle", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        tick(3);

        // Bits 1,0,1,1 back-to-back: phase 120 after the first bit.
        a_spot.delete(); a_spot[1500] = 8'd238; a_spot[1501] = 8'd237;
        a_phase = 0; a_pushed = 0;
        xfer(0, 1'b1); push_model_a(1'b1);
        xfer(0, 1'b0); push_model_a(1'b0);
        xfer(0, 1'b1); push_model_a(1'b1);
        xfer(0, 1'b1); a_bv = 1'b0; push_model_a(1'b1);
        tick(1500);
        expect_req(0, 1, "a_burst_drain");
        tick(1);
        expect_state(0, "a_burst_idle", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        tick(3);

        // Asynchronous reset mid-bit: outputs clear before any clock edge.
        a_spot.delete(); a_phase = 0; a_pushed = 0;
        xfer(0, 1'b1);
        a_bv = 1'b0;
        push_model_a(1'b1);
        tick(700);
        rst = 1'b1;
        qa.delete();
        expect_state(0, "a_async_reset", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        expect_state(0, "a_after_reset", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        tick(4);

        // Short bits: space bit with bit_valid dropped, ready only at cnt=3 / IDLE.
        xfer(1, 1'b0);
        b_bv = 1'b0;
        for (int i = 0; i < 4; i++) qb.push_back(space4_exp[i]);
        expect_state(1, "b_ready_cnt0", 0, 8'd0, 0, 1'b0, 1, 1'b0);
        tick(1);
        expect_state(1, "b_ready_cnt1", 0, 8'd0, 0, 1'b0, 1, 1'b0);
        tick(1);
        expect_state(1, "b_ready_cnt2", 0, 8'd0, 0, 1'b0, 1, 1'b0);
        tick(1);
        expect_state(1, "b_ready_cnt3", 0, 8'd0, 0, 1'b0, 1, 1'b1);
        tick(1);
        expect_state(1, "b_ready_last_out", 0, 8'd0, 1, 1'b1, 1, 1'b1);
        tick(1);
        expect_state(1, "b_gap_idle", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        expect_req(1, 1, "b_gap_drain");
        tick(1);

        // Two mark bits at step 179: phase wraps without leaving 0..359.
        xfer(1, 1'b1);
        for (int i = 0; i < 4; i++) qb.push_back(wrap_exp[i]);
        xfer(1, 1'b1);
        b_bv = 1'b0;
        for (int i = 4; i < 8; i++) qb.push_back(wrap_exp[i]);
        tick(4);
        expect_req(1, 1, "b_wrap_drain");
        tick(1);
        expect_state(1, "b_wrap_idle", 1, 8'd128, 1, 1'b0, 1, 1'b1);
        tick(2);

        expect_req(0, 1, "a_final_drain");
        expect_req(1, 1, "b_final_drain");
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsk_modulator.md
# fsk_modulator

Binary FSK transmitter that is the counterpart of the `detection` receiver. It accepts one data bit at a time over a valid/ready handshake and emits a continuous-phase stream of unsigned 8-bit sine samples, one per clock. The sample stream drives `detection.A` directly or feeds a DAC. Bit `1` uses the mark tone and bit `0` the space tone, which runs at half the mark frequency by default.

## Interface
- `SAMPLES_PER_BIT`, 1500: samples emitted per data bit; must be ≥2.
- `STEP_MARK`, 2: phase increment per sample for bit `1`, in table entries (1..179).
- `STEP_SPACE`, 1: phase increment per sample for bit `0` (1..179).
- `clk`  in  1: sample clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `bit_valid`  in  1: `bit_in` holds a bit to send.
- `bit_in`  in  1: data bit.
- `bit_ready`  out  1: modulator accepts a bit this cycle.
- `sample`  out  8: unsigned offset-binary sine sample; midscale is 128.
- `sample_valid`  out  1: `sample` belongs to a transmitted bit.

## Operation
- Sine table: `sine[k] = 128 + round(127·sin(2πk/360))`, k = 0..359.
  - Range 1..255; sine[0]=128, sine[90]=255, sine[180]=128, sine[270]=1.
- States:
  - IDLE: no bit in flight.
  - SEND: `cur_bit` is being transmitted; `cnt` counts 0..SAMPLES_PER_BIT-1.
- `bit_ready` = (state==IDLE) || (state==SEND && cnt==SAMPLES_PER_BIT-1).
  - It is a function of state only and never depends on `bit_valid`.
- Transfer occurs on an edge where `bit_valid && bit_ready`.
- IDLE, on transfer: `cur_bit`←`bit_in`, `cnt`←0, state←SEND.
- SEND, every edge:
  - `sample`←sine[phase] and `sample_valid`←1.
  - phase←(phase+step) mod 360, with step = `cur_bit` ? STEP_MARK : STEP_SPACE.
  - `cnt`←`cnt`+1.
- SEND, when `cnt`==last:
  - This edge still emits the last sample of the old bit.
  - On transfer: `cur_bit`←`bit_in`, `cnt`←0, stay in SEND. Phase carries over, so there is no gap and no phase jump.
  - With no transfer: state←IDLE.
- IDLE, every edge (macro off): `sample`←128, `sample_valid`←0, phase←0. Each burst therefore starts at phase 0.
- Phase wrap arithmetic:
  - phase is 9 bits; the sum is formed in 10 bits.
  - If sum ≥ 360, subtract 360. A single subtraction is sufficient because each step is ≤179.
- Reset (asynchronous, any state, including mid-bit):
  - state=IDLE, cnt=0, cur_bit=0, phase=0.
  - `sample`=128, `sample_valid`=0, so `bit_ready`=1.
  - The bit in flight is discarded.

## Timing
- Throughput: one sample per clock.
  - A bit lasts exactly SAMPLES_PER_BIT cycles of `sample_valid`=1.
- Latency: a bit transferred at edge E produces its first sample at edge E+1.
- Back-to-back: if `bit_valid` is held high, the stream is gapless. Bits take SAMPLES_PER_BIT cycles each, including the first.
- `sample` and `sample_valid` are registered with no combinational path from any input.
  - The ROM lookup is combinational from the phase register; the ROM output is registered into `sample`.

## Configuration
- `FSK_IDLE_MARK_EN`
  - Defined: in IDLE, the modulator transmits the mark tone continuously. `sample`←sine[phase], phase advances by STEP_MARK, and `sample_valid`=1. Phase is not cleared on entering IDLE, so bursts start at the current phase. Reset values are unchanged.
  - Undefined: IDLE behaves as described in Operation (silence at 128, phase cleared).

## Structure
- Package `fsk_pkg`:
  - State enum {IDLE, SEND}.
  - Constants PHASE_W=9, PHASE_MOD=360, SAMPLE_W=8, MIDSCALE=8'd128.
- Sub-module `fsk_sine_rom`:
  - Combinational; 9-bit phase in, 8-bit sample out.
  - Stores the 91-entry quarter wave (k=0..90) and derives the other quadrants by index mirroring and reflection about 128. Reflection is `256 - q`, which maps 255 to 1.

## Test plan
- Reset → `sample`=128, `sample_valid`=0, `bit_ready`=1; assert `rst` mid-bit (sample 700) → same values on the next observation with no edge required.
- Single `1`, defaults → 1500 valid samples sine[0], sine[2], …; sample #45 = 255, #135 = 1; then `sample_valid`=0 and `sample`=128.
- Bits 1,0,1,1 with `bit_valid` held → 6000 contiguous valid samples. After the first bit, phase = 3000 mod 360 = 120, so sample #1500 (the first space sample) = sine[120] = 238, and the following space samples advance by one entry.
- SAMPLES_PER_BIT=4; `bit_valid` low at the last sample → IDLE for at least one cycle. The next bit starts at sample 128 (phase 0), and `bit_ready` is high only in IDLE or at cnt=3.
- Wrap: STEP_MARK=179, bit `1` → phase sequence 0, 179, 358, 177, 356, … with no index ≥360.
- `FSK_IDLE_MARK_EN` defined, no bits offered → continuous valid mark tone (128, sine[2], sine[4], …). A bit `0` offered mid-tone continues from the current phase.
